alu_shift_sequencer: RTL



---
 rtl/alu_shift_sequencer_if.sv | 33 +++
 rtl/alu_shift_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer_if.sv
// Bundle between the shift sequencer, its requester (pipeline control) and the ALU.
// The master side is the requester plus the ALU; the slave side is the sequencer.
interface alu_shift_sequencer_if #(
    parameter int n   = 32,
    parameter int SHW = 5
);
    // Request side
    logic           start;
    logic [1:0]     op;
    logic [n-1:0]   operand;
    logic [SHW-1:0] shamt;
    logic           flush;
    logic           busy;
    logic           stall;
    logic           done;
    logic [n-1:0]   result;

    // ALU side
    logic [n-1:0]   alu_result;
    logic [n-1:0]   alu_a;
    logic [n-1:0]   alu_b;
    logic [3:0]     alu_control;

    modport master (
        output start, op, operand, shamt, flush, alu_result,
        input  busy, stall, done, result, alu_a, alu_b, alu_control
    );

    modport slave (
        input  start, op, operand, shamt, flush, alu_result,
        output busy, stall, done, result, alu_a, alu_b, alu_control
    );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle variable shifter: drives the ALU's 1-bit shift ops once per cycle,
// feeding ALUout back into an accumulator, and stalls the pipeline until done.
`ifndef ALU_PASS
`define ALU_PASS 4'b1111
`endif
`ifndef ALU_SLL
`define ALU_SLL  4'b0100
`endif
`ifndef ALU_SRL
`define ALU_SRL  4'b0101
`endif
`ifndef ALU_SRA
`define ALU_SRA  4'b0110
`endif

module alu_shift_sequencer #(
    parameter int n   = 32,
    parameter int SHW = 5
) (
    input logic                  clk,
    input logic                  rst,
    alu_shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    state_t         state;
    logic [n-1:0]   acc;
    logic [SHW-1:0] cnt;
    logic [1:0]     op_q;
    logic [n-1:0]   result_q;
    logic           done_q;

    // Sequencer FSM: accept a request, run one ALU pass per cycle, publish the result.
    // NOTE: all state here uses non-blocking assignments so every register sees
    // the pre-edge values of the others, which is what the hardware does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            op_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // flush beats a simultaneous start
                    if (bus.start && !bus.flush) begin
                        acc  <= bus.operand;
                        op_q <= bus.op;
                        cnt  <= bus.shamt;
                        if (bus.shamt == '0 || bus.op == OP_RSVD) begin
                            // Nothing to shift: the operand is already the answer.
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= bus.operand;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= bus.alu_result;
                        cnt <= cnt - SHW'(1);
                        // Last pass: capture the ALU output directly so result is
                        // valid in the same cycle done is raised.
                        if (cnt == SHW'(1)) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= bus.alu_result;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ALU op select: a shift op only while iterating, otherwise pass A through.
    // NOTE: the default assignment first keeps this purely combinational (no latch).
    always_comb begin
        bus.alu_control = `ALU_PASS;
        if (state == SHIFT) begin
            case (op_q)
                OP_SLL:  bus.alu_control = `ALU_SLL;
                OP_SRL:  bus.alu_control = `ALU_SRL;
                OP_SRA:  bus.alu_control = `ALU_SRA;
                default: bus.alu_control = `ALU_PASS;
            endcase
        end
    end

    assign bus.alu_a  = acc;
    assign bus.alu_b  = '0;
    assign bus.busy   = (state != IDLE);
    // Freeze the pipeline in the same cycle a request arrives, before it is accepted.
    assign bus.stall  = (state != IDLE) || (bus.start && (state == IDLE));
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule
